// File: rtl/recep_cmd_tx.sv
// Command transmitter for the keyboard-command receiver.
// Turns one parallel command into the receiver's scan-code byte sequence. Each byte is driven
// on Dato and then strobed with flag. Every sequence leads with 8'h43 so the receiver always
// starts from its idle state.
module recep_cmd_tx #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned HIGH_CYC  = 4,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_type,
    input  logic [7:0] temp_tens,
    input  logic [7:0] temp_units,
    output logic       cmd_ready,
    output logic [7:0] Dato,
    output logic       flag,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    localparam logic [2:0] TYPE_TEMP    = 3'd0;
    localparam logic [2:0] TYPE_ALERT   = 3'd1;
    localparam logic [2:0] TYPE_DANGER  = 3'd2;
    localparam logic [2:0] TYPE_GAS_ON  = 3'd3;
    localparam logic [2:0] TYPE_GAS_OFF = 3'd4;
    localparam logic [2:0] TYPE_RESET   = 3'd5;

    typedef enum logic [2:0] {StIdle, StCheck, StSetup, StStrobe, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       type_q, type_d;
    logic [7:0]       tens_q, tens_d;
    logic [7:0]       units_q, units_d;
    logic [7:0]       dato_q, dato_d;
    logic             flag_q, flag_d;
    logic             illegal;
    logic [1:0]       last_idx;

    // Codes the receiver treats as commands; a digit equal to one would derail its FSM.
    function automatic logic is_reserved(input logic [7:0] b);
        case (b)
            8'h2D, 8'h5A, 8'h43, 8'h4D, 8'h1C, 8'h34, 8'h33, 8'h35, 8'h31: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] seq_byte(input logic [2:0] t, input logic [1:0] idx,
                                            input logic [7:0] tens, input logic [7:0] units);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0: b = 8'h43;
            2'd1: begin
                case (t)
                    TYPE_TEMP:                 b = 8'h5A;
                    TYPE_ALERT, TYPE_DANGER:   b = 8'h33;
                    TYPE_GAS_ON, TYPE_GAS_OFF: b = 8'h34;
                    TYPE_RESET:                b = 8'h2D;
                    default:                   b = 8'h00;
                endcase
            end
            2'd2: begin
                case (t)
                    TYPE_TEMP:    b = tens;
                    TYPE_ALERT:   b = 8'h1C;
                    TYPE_DANGER:  b = 8'h4D;
                    TYPE_GAS_ON:  b = 8'h35;
                    TYPE_GAS_OFF: b = 8'h31;
                    default:      b = 8'h00;  // RESET pad byte
                endcase
            end
            default: b = units;
        endcase
        return b;
    endfunction

    // Legality of the latched command and its sequence length.
    always_comb begin
        illegal  = (type_q > TYPE_RESET) ||
                   ((type_q == TYPE_TEMP) && (is_reserved(tens_q) || is_reserved(units_q)));
        last_idx = (type_q == TYPE_TEMP) ? 2'd3 : 2'd2;
    end

    // Next-state logic: sequencer FSM, phase counter, byte index and output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        type_d  = type_q;
        tens_d  = tens_q;
        units_d = units_q;
        dato_d  = dato_q;
        flag_d  = flag_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    type_d  = cmd_type;
                    tens_d  = temp_tens;
                    units_d = temp_units;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (illegal) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    dato_d  = seq_byte(type_q, 2'd0, tens_q, units_q);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == HIGH_LAST) begin
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        dato_d  = 8'h00;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        dato_d  = seq_byte(type_q, idx_q + 2'd1, tens_q, units_q);
                        state_d = StSetup;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                dato_d  = 8'h00;
                flag_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence and drops flag at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            type_q  <= 3'd0;
            tens_q  <= 8'h00;
            units_q <= 8'h00;
            dato_q  <= 8'h00;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            dato_q  <= dato_d;
            flag_q  <= flag_d;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        done      = (state_q == StDone);
        err       = (state_q == StCheck) && illegal;
        Dato      = dato_q;
        flag      = flag_q;
    end

endmodule

// File: tb/tb_recep_cmd_tx.sv
// Directed self-checking bench for recep_cmd_tx.
module tb_recep_cmd_tx;

    logic       CLK;
    logic       RST_N;
    logic       cmd_valid;
    logic [2:0] cmd_type;
    logic [7:0] temp_tens;
    logic [7:0] temp_units;
    logic       cmd_ready;
    logic [7:0] Dato;
    logic       flag;
    logic       done;
    logic       err;

    int nchecks = 0;
    int nfail   = 0;

    logic [7:0] bytes_q[$];
    int         widths_q[$];
    int         hi_cnt      = 0;
    int         dato_viol   = 0;
    logic       mon_prev_flag = 1'b0;
    logic [7:0] mon_prev_dato = 8'h00;

    recep_cmd_tx dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .temp_tens (temp_tens),
        .temp_units(temp_units),
        .cmd_ready (cmd_ready),
        .Dato      (Dato),
        .flag      (flag),
        .done      (done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record the byte under each flag pulse, pulse widths, and any Dato change while flag is high.
    always @(negedge CLK) begin
        if (flag && !mon_prev_flag) begin
            bytes_q.push_back(Dato);
            hi_cnt = 1;
        end else if (flag) begin
            hi_cnt++;
            if (Dato !== mon_prev_dato) dato_viol++;
        end
        if (!flag && mon_prev_flag) widths_q.push_back(hi_cnt);
        mon_prev_flag = flag;
        mon_prev_dato = Dato;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        widths_q.delete();
        dato_viol = 0;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] t, input logic [7:0] tens,
                           input logic [7:0] units, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                           input int exp_cycles, input bit exp_err, input bit disturb);
        logic [7:0] exp_b[4];
        int         k;
        int         busy_viol;
        bit         got_done;
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        exp_b[3] = e3;
        clear_mon();
        @(negedge CLK);
        check({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_type   = t;
        temp_tens  = tens;
        temp_units = units;
        cmd_valid  = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        k = 1;
        check({tag, ".ready_busy"}, 32'(cmd_ready), 32'd0);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        if (exp_err) begin
            @(negedge CLK);
            check({tag, ".ready_after_err"}, 32'(cmd_ready), 32'd1);
            check({tag, ".err_one_cycle"}, 32'(err), 32'd0);
            check({tag, ".no_strobe"}, 32'(bytes_q.size()), 32'd0);
            return;
        end
        busy_viol = 0;
        got_done  = 1'b0;
        while (!got_done && k < 300) begin
            if (disturb) begin
                cmd_valid = k[0];
                temp_tens = 8'(k);
                cmd_type  = 3'd5;
            end
            @(negedge CLK);
            k++;
            if (done) got_done = 1'b1;
            else if (cmd_ready) busy_viol++;
        end
        cmd_valid = 1'b0;
        check({tag, ".done_seen"}, 32'(got_done), 32'd1);
        check({tag, ".done_cycle"}, 32'(k), 32'(exp_cycles));
        check({tag, ".dato_done"}, 32'(Dato), 32'h00);
        check({tag, ".busy"}, 32'(busy_viol), 32'd0);
        check({tag, ".nbytes"}, 32'(bytes_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check({tag, ".byte"}, 32'(bytes_q[i]), 32'(exp_b[i]));
        for (int i = 0; i < widths_q.size(); i++)
            check({tag, ".width"}, 32'(widths_q[i]), 32'd4);
        check({tag, ".dato_stable"}, 32'(dato_viol), 32'd0);
    endtask

    initial begin
        int  w;
        bit  found;
        RST_N      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_type   = 3'd0;
        temp_tens  = 8'h00;
        temp_units = 8'h00;
        #12;
        check("reset.ready", 32'(cmd_ready), 32'd1);
        check("reset.dato", 32'(Dato), 32'h00);
        check("reset.flag", 32'(flag), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Basic TEMP
        run_cmd("temp", 3'd0, 8'h16, 8'h1E, 4, 8'h43, 8'h5A, 8'h16, 8'h1E, 66, 1'b0, 1'b0);
        // Back-to-back DANGER, GAS_ON
        run_cmd("danger", 3'd2, 8'h00, 8'h00, 3, 8'h43, 8'h33, 8'h4D, 8'h00, 50, 1'b0, 1'b0);
        run_cmd("gas_on", 3'd3, 8'h00, 8'h00, 3, 8'h43, 8'h34, 8'h35, 8'h00, 50, 1'b0, 1'b0);
        // Rejections
        run_cmd("rej_tens", 3'd0, 8'h5A, 8'h1E, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0);
        run_cmd("rej_type7", 3'd7, 8'h16, 8'h1E, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0);
        run_cmd("rej_units", 3'd0, 8'h16, 8'h1C, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0);
        // ALERT then RESET, plus GAS_OFF
        run_cmd("alert", 3'd1, 8'h00, 8'h00, 3, 8'h43, 8'h33, 8'h1C, 8'h00, 50, 1'b0, 1'b0);
        run_cmd("reset_cmd", 3'd5, 8'h00, 8'h00, 3, 8'h43, 8'h2D, 8'h00, 8'h00, 50, 1'b0, 1'b0);
        run_cmd("gas_off", 3'd4, 8'h00, 8'h00, 3, 8'h43, 8'h34, 8'h31, 8'h00, 50, 1'b0, 1'b0);

        // Async reset during the strobe of the second TEMP byte
        clear_mon();
        @(negedge CLK);
        cmd_type   = 3'd0;
        temp_tens  = 8'h16;
        temp_units = 8'h1E;
        cmd_valid  = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        found = 1'b0;
        w = 0;
        while (!found && w < 200) begin
            @(negedge CLK);
            #1;
            w++;
            if (flag && bytes_q.size() == 2) found = 1'b1;
        end
        check("midrst.reach_strobe", 32'(found), 32'd1);
        check("midrst.dato_before", 32'(Dato), 32'h5A);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst.flag", 32'(flag), 32'd0);
        check("midrst.dato", 32'(Dato), 32'h00);
        check("midrst.ready", 32'(cmd_ready), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        clear_mon();
        run_cmd("temp_after_rst", 3'd0, 8'h16, 8'h1E, 4, 8'h43, 8'h5A, 8'h16, 8'h1E, 66,
                1'b0, 1'b0);

        // Inputs wiggled mid-sequence must not disturb the latched command
        run_cmd("disturb", 3'd0, 8'h16, 8'h1E, 4, 8'h43, 8'h5A, 8'h16, 8'h1E, 66, 1'b0, 1'b1);
        temp_tens = 8'h00;
        cmd_type  = 3'd0;
        @(negedge CLK);
        check("final.ready", 32'(cmd_ready), 32'd1);
        check("final.flag", 32'(flag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
